// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Default word geometry: four bytes per 32-bit FIFO word.
    localparam int DEF_BEATS   = 4;
    localparam int DEF_NUM_REQ = 4;

    // Widest request vector the round-robin helper handles.
    localparam int RR_MAX = 32;

    // Round-robin search. Returns the first set bit of req, searching upward
    // from (last+1) mod n with wrap. Returns last when no bit is set.
    function automatic int rr_next(input int last, input logic [RR_MAX-1:0] req, input int n);
        int  idx;
        int  pick;
        bit  found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector over the producer request vector.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int GNT_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [GNT_WIDTH-1:0] last_gnt,
    output logic [GNT_WIDTH-1:0] pick,
    output logic                 any_req
);

    logic [RR_MAX-1:0] req_ext;

    // Widen the request vector to the helper's fixed width, then search.
    always_comb begin
        req_ext = RR_MAX'(req);
        any_req = |req;
        pick    = GNT_WIDTH'(rr_next(int'(last_gnt), req_ext, NUM_REQ));
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO's byte write port between producers.
// A grant is held for a whole word so FIFO words are never interleaved.
//
// Handshake: a producer byte transfers in a cycle where req_valid[i] and
// req_ready[i] are both high at the rising edge. req_ready[i] never depends
// on req_valid[i]; a producer must hold req_valid and its byte stable until
// the transfer happens. On the FIFO side fifo_wr_en is the write strobe and
// is only raised when fifo_full is low.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = 8,
    parameter int BEATS      = DEF_BEATS,
    parameter int GNT_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic                          gnt_valid,
    output logic [GNT_WIDTH-1:0]          gnt_id,
    output logic                          word_done,
    output state_t                        dbg_state,
    output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] dbg_beat_cnt
);

    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                 state;
    logic [BCW-1:0]         beat_cnt;
    logic [GNT_WIDTH-1:0]   gnt_id_q;
    logic [GNT_WIDTH-1:0]   last_gnt;
    logic [GNT_WIDTH-1:0]   pick;
    logic                   any_req;
    logic                   accept;
    logic                   last_beat;

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .GNT_WIDTH (GNT_WIDTH)
    ) u_picker (
        .req      (req_valid),
        .last_gnt (last_gnt),
        .pick     (pick),
        .any_req  (any_req)
    );

    // Byte transfer and end-of-word detection for the owning producer.
    always_comb begin
        accept    = (state == BURST) && req_valid[gnt_id_q] && !fifo_full;
        last_beat = (beat_cnt == BCW'(BEATS - 1));
        word_done = accept && last_beat;
        fifo_wr_en = accept;
        gnt_valid  = (state == BURST);
    end

    // Route the owner's byte and ready; everything is quiet in IDLE.
    always_comb begin
        req_ready   = '0;
        fifo_w_data = '0;
        if (state == BURST) begin
            req_ready[gnt_id_q] = !fifo_full;
            fifo_w_data         = req_data[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Arbitration FSM: grant in IDLE, count beats in BURST, rotate priority on word end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            gnt_id_q <= '0;
            last_gnt <= GNT_WIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id_q <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            last_gnt <= gnt_id_q;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_id       = gnt_id_q;
    assign dbg_state    = state;
    assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: grant order, word integrity, stalls, reset.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BT = 4;
    localparam int GW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    fifo_w_data;
    logic             fifo_wr_en;
    logic             fifo_full = 1'b0;
    logic             gnt_valid;
    logic [GW-1:0]    gnt_id;
    logic             word_done;
    state_t           dbg_state;
    logic [1:0]       dbg_beat_cnt;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BEATS      (BT),
        .GNT_WIDTH  (GW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_w_data  (fifo_w_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_full    (fifo_full),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .word_done    (word_done),
        .dbg_state    (dbg_state),
        .dbg_beat_cnt (dbg_beat_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          done_cyc[$];
    logic [31:0] asm_word = '0;
    int          cyc = 0;

    // Assemble FIFO words LSB-first and compare each completed word.
    always @(posedge clk) begin
        logic [31:0] w;
        cyc = cyc + 1;
        if (rst_n && fifo_wr_en) begin
            w = {fifo_w_data, asm_word[31:8]};
            asm_word = w;
            if (word_done) begin
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("word_unexpected", w, 32'hDEADBEEF);
                end else begin
                    chk("word", w, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Cycle spent in IDLE with requests pending: nothing may transfer.
    task automatic idle_grant();
        #1;
        chk("idle_state", 32'(dbg_state), 32'(IDLE));
        chk("idle_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("idle_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd0);
        tick();
    endtask

    // One accepted beat from producer id.
    task automatic do_beat(input int id, input logic [7:0] b, input int beat);
        req_data[id*DW +: DW] = b;
        #1;
        chk("beat_gnt_valid", 32'(gnt_valid), 32'd1);
        chk("beat_gnt_id", 32'(gnt_id), 32'(id));
        chk("beat_cnt", 32'(dbg_beat_cnt), 32'(beat));
        chk("beat_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("beat_data", 32'(fifo_w_data), 32'(b));
        chk("beat_ready", 32'(req_ready), 32'(1 << id));
        chk("beat_word_done", 32'(word_done), 32'(beat == BT - 1));
        tick();
    endtask

    // Granted but not transferring (producer gap or FIFO full).
    task automatic stall_cycle(input int id, input int beat, input logic [3:0] exp_ready);
        #1;
        chk("stall_gnt_valid", 32'(gnt_valid), 32'd1);
        chk("stall_gnt_id", 32'(gnt_id), 32'(id));
        chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("stall_ready", 32'(req_ready), 32'(exp_ready));
        chk("stall_cnt", 32'(dbg_beat_cnt), 32'(beat));
        chk("stall_word_done", 32'(word_done), 32'd0);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ids[5];
        ids = '{0, 1, 2, 3, 0};

        // Reset values.
        #2;
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_word_done", 32'(word_done), 32'd0);
        chk("rst_w_data", 32'(fifo_w_data), 32'd0);
        chk("rst_beat_cnt", 32'(dbg_beat_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single producer 2, bytes A0..A3.
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'hA0;
        exp_q.push_back(32'hA3A2A1A0);
        idle_grant();
        for (int b = 0; b < BT; b++) do_beat(2, 8'(8'hA0 + b), b);

        // All producers continuously valid, from a fresh reset: order 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            exp_q.push_back({4{8'(8'hB0 + ids[w])}});
            idle_grant();
            for (int b = 0; b < BT; b++) do_beat(ids[w], 8'(8'hB0 + ids[w]), b);
        end

        // Producer 1 gaps for 3 cycles while producer 0 keeps requesting.
        req_valid = 4'b0011;
        req_data[0 +: DW] = 8'hEE;
        exp_q.push_back(32'hC3C2C1C0);
        idle_grant();
        do_beat(1, 8'hC0, 0);
        do_beat(1, 8'hC1, 1);
        req_valid = 4'b0001;
        for (int g = 0; g < 3; g++) stall_cycle(1, 2, 4'b0010);
        req_valid = 4'b0011;
        do_beat(1, 8'hC2, 2);
        do_beat(1, 8'hC3, 3);

        // FIFO full for 5 cycles after two beats of producer 2.
        req_valid = 4'b0100;
        exp_q.push_back(32'hD3D2D1D0);
        idle_grant();
        do_beat(2, 8'hD0, 0);
        do_beat(2, 8'hD1, 1);
        fifo_full = 1'b1;
        req_data[2*DW +: DW] = 8'hD2;
        for (int g = 0; g < 5; g++) stall_cycle(2, 2, 4'b0000);
        fifo_full = 1'b0;
        do_beat(2, 8'hD2, 2);
        do_beat(2, 8'hD3, 3);

        // Reset mid-word of producer 3, then producers 0 and 3 contend.
        req_valid = 4'b1001;
        idle_grant();
        do_beat(3, 8'h30, 0);
        do_beat(3, 8'h31, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("midrst_word_done", 32'(word_done), 32'd0);
        chk("midrst_w_data", 32'(fifo_w_data), 32'd0);
        chk("midrst_gnt_id", 32'(gnt_id), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        exp_q.push_back(32'hF3F2F1F0);
        idle_grant();
        for (int b = 0; b < BT; b++) do_beat(0, 8'(8'hF0 + b), b);

        // Producer 3 streams 8 bytes: two words, one bubble, done pulses 5 apart.
        req_valid = 4'b1000;
        done_cyc.delete();
        exp_q.push_back(32'hE3E2E1E0);
        exp_q.push_back(32'hE7E6E5E4);
        idle_grant();
        for (int b = 0; b < BT; b++) do_beat(3, 8'(8'hE0 + b), b);
        idle_grant();
        for (int b = 0; b < BT; b++) do_beat(3, 8'(8'hE4 + b), b);
        req_valid = '0;
        repeat (2) tick();
        chk("stream_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) chk("stream_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'd5);
        chk("final_state", 32'(dbg_state), 32'(IDLE));
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the byte-in/word-out FIFO. It shares the FIFO's single 8-bit write port between NUM_REQ byte producers. A granted producer keeps the port for a whole word of BEATS bytes, so the 32-bit words the consumer reads are never interleaved across producers. It sits directly in front of the FIFO's write interface: w_data, wr_en and full.

## Interface
Parameters:
- NUM_REQ, 4, number of byte producers (≥2)
- DATA_WIDTH, 8, producer byte width; equals FIFO DATA_WIDTH
- BEATS, 4, bytes per word; equals FIFO READ_WIDTH/DATA_WIDTH
- GNT_WIDTH, $clog2(NUM_REQ), width of grant index

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  producer i has a byte on req_data slice i
- req_data  in  NUM_REQ*DATA_WIDTH  producer bytes; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  byte of producer i accepted this cycle when req_valid[i] is also high
- fifo_w_data  out  DATA_WIDTH  to FIFO w_data
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_full  in  1  from FIFO full
- gnt_valid  out  1  a producer currently owns the port
- gnt_id  out  GNT_WIDTH  index of the owning producer
- word_done  out  1  one-cycle pulse when the last byte of a word is accepted

## Operation
- Two-state FSM, IDLE and BURST, registered.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from (last_gnt+1) mod NUM_REQ, with wrap.
  - Register it into gnt_id, clear beat_cnt, go to BURST.
  - If no req_valid is high, stay in IDLE.
- BURST:
  - accept = req_valid[gnt_id] && !fifo_full.
  - fifo_wr_en = accept.
  - fifo_w_data = slice gnt_id of req_data.
  - req_ready[gnt_id] = !fifo_full; every other req_ready bit is 0.
  - On accept, beat_cnt increments.
  - On accept when beat_cnt == BEATS-1: assert word_done, set last_gnt <= gnt_id, return to IDLE.
- The grant is held until the word completes.
  - A producer deasserting req_valid mid-word stalls the port; no timeout and no preemption.
- In IDLE: fifo_wr_en = 0, req_ready = 0, gnt_valid = 0.
- gnt_valid = (state == BURST).
- beat_cnt is $clog2(BEATS) bits wide and never exceeds BEATS-1.
- last_gnt resets to NUM_REQ-1, so producer 0 has first priority after reset.

## Timing
- Reset (async assert, sync release) forces:
  - state = IDLE, beat_cnt = 0, gnt_id = 0, last_gnt = NUM_REQ-1.
  - Outputs: fifo_wr_en = 0, req_ready = 0, gnt_valid = 0, word_done = 0, fifo_w_data = 0.
- Reset mid-word drops the partial word ownership. Bytes already written stay in the FIFO; clearing them is the FIFO's own reset's concern.
- Arbitration latency:
  - Request seen in IDLE at cycle N → grant at N+1 → first byte can be accepted at N+1.
  - Datapath is combinational from req_data to fifo_w_data; zero added latency.
- Each word costs one IDLE bubble cycle between grants, even for back-to-back words from the same producer. Peak throughput is BEATS bytes per BEATS+1 cycles.
- fifo_full high in BURST: no accept, beat_cnt holds, req_ready low. Resume on the first cycle fifo_full is low.
- word_done is combinational, coincident with the accepting edge's cycle. It is high exactly in the cycle fifo_wr_en carries beat BEATS-1.
- Simultaneous requests in IDLE resolve by the round-robin rule only. No request is starved longer than NUM_REQ-1 words.

## Structure
- Package fifo_arb_pkg:
  - state enum (IDLE, BURST).
  - localparam for the default BEATS.
  - function rr_next(last, req) returning the next index.
- Sub-module rr_picker:
  - Combinational round-robin selector.
  - Inputs: req vector and last_gnt.
  - Outputs: pick index and any_req.
- Top: FSM, beat counter, last_gnt register, and output muxing.

## Test plan
- Reset, then only req_valid[2] high with bytes 0xA0..0xA3:
  - gnt_id = 2 one cycle later.
  - fifo_w_data sequence A0, A1, A2, A3.
  - word_done on the A3 cycle.
  - FIFO reads 0xA3A2A1A0.
- All four producers valid continuously:
  - Grant order 0, 1, 2, 3, 0.
  - Each holds exactly 4 accepts.
  - One idle cycle between words.
- Producer 1 granted, drops req_valid after 2 bytes for 3 cycles while producer 0 stays valid:
  - Grant stays with 1.
  - No writes during the gap.
  - Word completes with 1's bytes only.
- fifo_full asserted after beat 1 for 5 cycles:
  - fifo_wr_en = 0 and req_ready = 0 during the stall.
  - beat_cnt holds at 2.
  - Remaining 2 beats are written after full drops.
- rst_n pulsed low mid-word (after 2 beats):
  - All outputs go to 0 immediately.
  - After release, the next grant goes to producer 0 when producers 0 and 3 both request.
- Single producer 3 streaming 8 bytes:
  - Two words, grant re-issued to 3 after one IDLE cycle.
  - word_done pulses twice, 5 cycles apart at full rate.
